iic_eeprom_slave: RTL and testbench
===================================

# iic_eeprom_slave

Synthesizable I2C target that emulates the 256-byte EEPROM at 7-bit device address 7'b1010_100. It is the responder for the board's EEPROM I2C master: it sits on the I2C_SCL/I2C_SDA pair in simulation benches and loopback builds, so the master's initialization and read paths can be exercised without the physical part. All bus sampling is oversampled on the single system clock.

## Interface
- IIC_DEV_AD, 7'b1010_100: device address this target answers.
- FILT_LEN, 3: number of consecutive equal samples (1–7) needed before a filtered SCL/SDA level changes.
- CLK  in  1: system clock. Must be at least 20× the SCL frequency.
- RSTn  in  1: reset, asynchronous assert, active-low.
- SCL_IN  in  1: I2C clock from the pad. Asynchronous to CLK.
- SDA_IN  in  1: I2C data from the pad. Asynchronous to CLK.
- SDA_OE  out  1: 1 = pull SDA low. The pad is open-drain and this block never drives it high.
- BUSY  out  1: high from a detected START until the next STOP.
- WR_STB  out  1: one-cycle pulse when a data byte is committed to memory.
- WR_ADDR  out  8: address of the committed byte. Held until the next commit.
- WR_DATA  out  8: value of the committed byte. Held until the next commit.
- WP  in  1: write protect. This port exists only when IIC_EEPROM_WP_EN is defined.

## Operation
- **Input conditioning.** SCL_IN and SDA_IN each pass through a 2-flop synchronizer, then a stability filter of FILT_LEN samples. This yields filtered levels scl and sda.
- **Bus events** (evaluated on filtered levels):
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
  - Data bits are sampled on the scl rising edge.
  - SDA_OE changes only on the scl falling edge.
- **States:** IDLE, DEV, DEV_ACK, WADR, WADR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT.
  - **START** from any state: go to DEV, clear the bit counter, set BUSY.
  - **STOP** from any state: go to IDLE, release SDA, clear BUSY. A partially shifted byte is discarded.
  - **DEV:** shift in 8 bits, MSB first.
    - If bits[7:1] == IIC_DEV_AD, go to DEV_ACK and drive ACK.
    - Otherwise go to WAIT with SDA released (NACK).
  - **DEV_ACK:**
    - R/W=0: go to WADR.
    - R/W=1: go to RDAT and load the shift register from mem[ptr].
  - **WADR:** 8 bits are written to ptr. Go to WADR_ACK (ACK), then WDAT.
  - **WDAT:** on the 8th bit, write mem[ptr] <= byte and pulse WR_STB.
    - WR_ADDR = ptr and WR_DATA = byte.
    - Then ptr <= ptr+1, wrapping 8'hFF to 8'h00.
    - ACK, then return to WDAT for the next byte.
  - **RDAT:** drive SDA_OE = ~bit (MSB first) for 8 bits. Then release SDA and sample the master's ACK bit.
    - Sampled 0 (ACK): ptr <= ptr+1 with wrap, reload the shift register, stay in RDAT.
    - Sampled 1 (NACK): go to WAIT.
  - **WAIT:** ignore all traffic until START or STOP.
- A repeated START after WADR keeps ptr. This gives the standard random read: write device+word address, repeated START, then device address with R/W=1.
- Memory is 256×8. RSTn does not clear it. The simulation initial value is 8'hFF for every byte.
- ptr resets to 8'h00.

## Timing
- **Reset values:** SDA_OE=0, BUSY=0, WR_STB=0, WR_ADDR=8'h00, WR_DATA=8'h00, state=IDLE, ptr=8'h00.
- **Pad-to-event latency:** 2 + FILT_LEN CLK cycles.
- SDA_OE updates 1 CLK after the filtered scl falling edge is detected.
- WR_STB asserts 1 CLK after the scl rising edge that carries the 8th data bit is detected.
- The ACK drive is released on the scl falling edge that ends the 9th clock.
- START and STOP take priority over a bit sample occurring in the same cycle.
- RSTn asserted mid-transfer releases SDA immediately (asynchronous). No partial write is committed.

## Configuration
- **IIC_EEPROM_WP_EN defined:** the WP port exists. While WP=1, data bytes are still ACKed and ptr still advances, but memory is not written and WR_STB stays low. WP is sampled at the 8th bit of each byte.
- **Not defined:** no WP port, and every write is committed.

## Test plan
- **Single-byte write then random read.** Write dev 0xA8, addr 0x10, data 0x5A, STOP. Then dev 0xA8, addr 0x10, repeated START, dev 0xA9, read 1 byte, NACK.
  - Expect WR_STB once with WR_ADDR=0x10 and WR_DATA=0x5A.
  - Expect the read to return 0x5A and every ACK slot to be low.
- **Sequential read across wrap.** After writing 0x11@0xFE, 0x22@0xFF, 0x33@0x00, read 3 bytes starting at 0xFE.
  - Expect 0x11, 0x22, 0x33.
- **Wrong device address.** Send dev 0xA0.
  - Expect SDA_OE=0 in the ACK slot, BUSY=1 until STOP, and no WR_STB.
- **Aborted byte.** STOP after 5 data bits.
  - Expect no WR_STB, memory unchanged, and state IDLE.
- **Reset during read.** Pull RSTn low while SDA_OE=1 during RDAT.
  - Expect SDA_OE=0 within the same cycle and all outputs at their reset values.
- **Write protect** (IIC_EEPROM_WP_EN defined). With WP=1, write 0x77@0x20.
  - Expect ACK and no WR_STB. A subsequent read of 0x20 returns the old value.

Source files
------------

// File: rtl/iic_eeprom_slave.sv
// iic_eeprom_slave: I2C target emulating a 256x8 EEPROM for master-side testing.
// SCL/SDA are oversampled on CLK (synchronizer + stability filter). After the
// device address it accepts a word address, then either writes data bytes or
// streams data bytes out. ptr auto-increments and wraps from 8'hFF to 8'h00.
// Ports:
//   CLK, RSTn        system clock, async active-low reset
//   SCL_IN, SDA_IN   pad inputs (asynchronous to CLK)
//   SDA_OE           1 = pull SDA low (open-drain; never driven high)
//   BUSY             high from START until STOP
//   WR_STB           one-cycle pulse when a data byte is committed
//   WR_ADDR/WR_DATA  address/value of the last committed byte
//   WP               write protect, present only with IIC_EEPROM_WP_EN defined
// Optional feature macro: IIC_EEPROM_WP_EN
module iic_eeprom_slave #(
    parameter logic [6:0]  IIC_DEV_AD = 7'b1010_100,
    parameter int unsigned FILT_LEN   = 3
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SDA_OE,
    output logic       BUSY,
    output logic       WR_STB,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA
`ifdef IIC_EEPROM_WP_EN
    ,
    input  logic       WP
`endif
);

    localparam int unsigned FCW = 3;
    localparam int unsigned BCW = 4;

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, WADR, WADR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_filt;
    logic [1:0]     r_filt_d;
    logic [FCW-1:0] r_fcnt [2];

    state_t         r_state, w_state_nxt;
    logic [BCW-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic [7:0]     r_ptr, w_ptr_nxt;
    logic           r_sda_oe, w_sda_oe_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_wr_stb, w_wr_stb_nxt;
    logic [7:0]     r_wr_addr, w_wr_addr_nxt;
    logic [7:0]     r_wr_data, w_wr_data_nxt;
    logic           w_mem_we;

    logic [7:0]     r_mem [256] = '{default: 8'hFF};

    logic w_scl, w_sda;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte_in, w_rd_byte;
    logic w_last_bit, w_wp;

`ifdef IIC_EEPROM_WP_EN
    assign w_wp = WP;
`else
    assign w_wp = 1'b0;
`endif

    // Synchronize and filter: a level change is accepted after FILT_LEN equal samples.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sync1  <= 2'b11;
            r_sync2  <= 2'b11;
            r_filt   <= 2'b11;
            r_filt_d <= 2'b11;
            r_fcnt   <= '{default: '0};
        end else begin
            r_sync1  <= {SDA_IN, SCL_IN};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FCW'(FILT_LEN - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + FCW'(1);
                end
            end
        end
    end

    assign w_scl      = r_filt[0];
    assign w_sda      = r_filt[1];
    assign w_scl_rise = w_scl & ~r_filt_d[0];
    assign w_scl_fall = ~w_scl & r_filt_d[0];
    assign w_start    = w_scl & r_filt_d[0] & r_filt_d[1] & ~w_sda;
    assign w_stop     = w_scl & r_filt_d[0] & ~r_filt_d[1] & w_sda;
    assign w_byte_in  = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bit_cnt == BCW'(7));
    assign w_rd_byte  = r_mem[r_ptr];

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_busy    <= w_busy_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[r_ptr] <= w_byte_in;
        end
    end

    // Next-state and output logic. START/STOP override any bit activity.
    // ACK states: first scl fall pulls SDA low, second scl fall releases it.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_oe_nxt  = r_sda_oe;
        w_busy_nxt    = r_busy;
        w_wr_stb_nxt  = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_mem_we      = 1'b0;

        if (w_start) begin
            w_state_nxt   = DEV;
            w_bit_cnt_nxt = '0;
            w_busy_nxt    = 1'b1;
            w_sda_oe_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt   = IDLE;
            w_bit_cnt_nxt = '0;
            w_busy_nxt    = 1'b0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                DEV: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in;
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = (w_byte_in[7:1] == IIC_DEV_AD) ? DEV_ACK : WAIT;
                        end
                    end
                end
                DEV_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else if (r_shift[0]) begin
                            // Read: first data bit goes out on the same fall that ends the ACK.
                            w_state_nxt   = RDAT;
                            w_shift_nxt   = w_rd_byte;
                            w_sda_oe_nxt  = ~w_rd_byte[7];
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_state_nxt  = WADR;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                WADR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in;
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            w_ptr_nxt     = w_byte_in;
                            w_state_nxt   = WADR_ACK;
                        end
                    end
                end
                WADR_ACK, WDAT_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = WDAT;
                        end
                    end
                end
                WDAT: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte_in;
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                        if (w_last_bit) begin
                            w_bit_cnt_nxt = '0;
                            if (!w_wp) begin
                                w_mem_we      = 1'b1;
                                w_wr_stb_nxt  = 1'b1;
                                w_wr_addr_nxt = r_ptr;
                                w_wr_data_nxt = w_byte_in;
                            end
                            w_ptr_nxt   = r_ptr + 8'd1;
                            w_state_nxt = WDAT_ACK;
                        end
                    end
                end
                RDAT: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == BCW'(8)) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = RDAT_ACK;
                        end else if (r_bit_cnt != '0) begin
                            w_shift_nxt  = {r_shift[6:0], r_shift[7]};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                RDAT_ACK: begin
                    // Only a master ACK leaves us here long enough to see the next fall.
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt = WAIT;
                        end else begin
                            w_ptr_nxt = r_ptr + 8'd1;
                        end
                    end else if (w_scl_fall) begin
                        w_state_nxt   = RDAT;
                        w_shift_nxt   = w_rd_byte;
                        w_sda_oe_nxt  = ~w_rd_byte[7];
                        w_bit_cnt_nxt = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign SDA_OE  = r_sda_oe;
    assign BUSY    = r_busy;
    assign WR_STB  = r_wr_stb;
    assign WR_ADDR = r_wr_addr;
    assign WR_DATA = r_wr_data;

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: bit-banged I2C master with open-drain SDA.
module tb_iic_eeprom_slave;

    localparam int Q = 10;  // quarter SCL period in CLK cycles

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       SCL_IN;
    logic       SDA_IN;
    logic       SDA_OE;
    logic       BUSY;
    logic       WR_STB;
    logic [7:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       scl_m;
    logic       sda_m;
`ifdef IIC_EEPROM_WP_EN
    logic       wp;
`endif

    int         checks = 0;
    int         errors = 0;
    int         stb_cnt = 0;
    logic [7:0] stb_addr = 8'h00;
    logic [7:0] stb_data = 8'h00;

    assign SCL_IN = scl_m;
    assign SDA_IN = sda_m & ~SDA_OE;

    always #5 CLK = ~CLK;

    iic_eeprom_slave dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .SCL_IN  (SCL_IN),
        .SDA_IN  (SDA_IN),
        .SDA_OE  (SDA_OE),
        .BUSY    (BUSY),
        .WR_STB  (WR_STB),
        .WR_ADDR (WR_ADDR),
        .WR_DATA (WR_DATA)
`ifdef IIC_EEPROM_WP_EN
        ,
        .WP      (wp)
`endif
    );

    always @(negedge CLK) begin
        if (WR_STB === 1'b1) begin
            stb_cnt  = stb_cnt + 1;
            stb_addr = WR_ADDR;
            stb_data = WR_DATA;
        end
    end

    task automatic wait_q(input int n);
        repeat (n * Q) @(posedge CLK);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b1; wait_q(2);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    wait_q(1);
        scl_m = 1'b1; wait_q(2);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        b = SDA_IN;   wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v, input logic m_ack);
        for (int i = 7; i >= 0; i--) get_bit(v[i]);
        put_bit(m_ack);
    endtask

    // Random-read preamble: dev write, word address, repeated START, dev read.
    task automatic read_setup(input logic [7:0] a, output logic [2:0] acks);
        bus_start;
        put_byte(8'hA8, acks[2]);
        put_byte(a, acks[1]);
        bus_start;
        put_byte(8'hA9, acks[0]);
    endtask

    task automatic test_reset;
        RSTn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
`ifdef IIC_EEPROM_WP_EN
        wp = 1'b0;
`endif
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        checks++; if (SDA_OE !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b exp 0", SDA_OE); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", BUSY); end
        checks++; if (WR_STB !== 1'b0) begin errors++; $display("FAIL rst_wr_stb got %b exp 0", WR_STB); end
        checks++; if (WR_ADDR !== 8'h00) begin errors++; $display("FAIL rst_wr_addr got %h exp 00", WR_ADDR); end
        checks++; if (WR_DATA !== 8'h00) begin errors++; $display("FAIL rst_wr_data got %h exp 00", WR_DATA); end
        RSTn = 1'b1;
        wait_q(2);
    endtask

    task automatic test_write_read;
        logic [2:0] acks;
        logic       a;
        logic [7:0] d;
        int         s0;
        s0 = stb_cnt;
        bus_start;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy got %b exp 1", BUSY); end
        put_byte(8'hA8, acks[2]);
        put_byte(8'h10, acks[1]);
        put_byte(8'h5A, acks[0]);
        bus_stop;
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL wr_acks got %b exp 000", acks); end
        checks++; if (stb_cnt !== s0 + 1) begin errors++; $display("FAIL wr_stb_count got %0d exp %0d", stb_cnt - s0, 1); end
        checks++; if (stb_addr !== 8'h10) begin errors++; $display("FAIL wr_addr got %h exp 10", stb_addr); end
        checks++; if (stb_data !== 8'h5A) begin errors++; $display("FAIL wr_data got %h exp 5a", stb_data); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_stop got %b exp 0", BUSY); end
        read_setup(8'h10, acks);
        get_byte(d, 1'b1);
        bus_stop;
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rd_acks got %b exp 000", acks); end
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rd_data got %h exp 5a", d); end
        a = 1'b0;
        checks++; if (stb_cnt !== s0 + 1) begin errors++; $display("FAIL rd_no_stb got %0d exp %0d", stb_cnt - s0, 1); end
    endtask

    task automatic test_wrap;
        logic [2:0] acks;
        logic [3:0] wacks;
        logic [7:0] d0, d1, d2;
        int         s0;
        s0 = stb_cnt;
        bus_start;
        put_byte(8'hA8, wacks[3]);
        put_byte(8'hFE, wacks[2]);
        put_byte(8'h11, wacks[1]);
        put_byte(8'h22, wacks[0]);
        put_byte(8'h33, acks[0]);
        bus_stop;
        checks++; if ({wacks, acks[0]} !== 5'b00000) begin errors++; $display("FAIL wrap_wacks got %b exp 00000", {wacks, acks[0]}); end
        checks++; if (stb_cnt !== s0 + 3) begin errors++; $display("FAIL wrap_stb_count got %0d exp 3", stb_cnt - s0); end
        checks++; if ({stb_addr, stb_data} !== 16'h0033) begin errors++; $display("FAIL wrap_last_wr got %h exp 0033", {stb_addr, stb_data}); end
        read_setup(8'hFE, acks);
        get_byte(d0, 1'b0);
        get_byte(d1, 1'b0);
        get_byte(d2, 1'b1);
        bus_stop;
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL wrap_racks got %b exp 000", acks); end
        checks++; if ({d0, d1, d2} !== 24'h112233) begin errors++; $display("FAIL wrap_read got %h exp 112233", {d0, d1, d2}); end
    endtask

    task automatic test_wrong_dev;
        logic a0, a1;
        int   s0;
        s0 = stb_cnt;
        bus_start;
        put_byte(8'hA0, a0);
        checks++; if (a0 !== 1'b1) begin errors++; $display("FAIL wdev_nack got %b exp 1", a0); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wdev_busy got %b exp 1", BUSY); end
        put_byte(8'h00, a1);
        checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL wdev_ignored got %b exp 1", a1); end
        bus_stop;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL wdev_busy_stop got %b exp 0", BUSY); end
        checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL wdev_stb got %0d exp 0", stb_cnt - s0); end
    endtask

    task automatic test_abort;
        logic [2:0] acks;
        logic [1:0] wacks;
        logic [7:0] d;
        int         s0;
        s0 = stb_cnt;
        bus_start;
        put_byte(8'hA8, wacks[1]);
        put_byte(8'h30, wacks[0]);
        for (int i = 0; i < 5; i++) put_bit(1'b0);
        bus_stop;
        checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL abort_stb got %0d exp 0", stb_cnt - s0); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", BUSY); end
        read_setup(8'h30, acks);
        get_byte(d, 1'b1);
        bus_stop;
        checks++; if ({wacks, acks} !== 5'b00000) begin errors++; $display("FAIL abort_acks got %b exp 00000", {wacks, acks}); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL abort_mem got %h exp ff", d); end
    endtask

    task automatic test_reset_read;
        logic [2:0] acks;
        logic [7:0] d;
        read_setup(8'h10, acks);
        // 0x10 holds 0x5A: MSB is 0, so the target is pulling SDA low now.
        checks++; if (SDA_OE !== 1'b1) begin errors++; $display("FAIL rrd_pre_oe got %b exp 1", SDA_OE); end
        RSTn = 1'b0;
        #1;
        checks++; if (SDA_OE !== 1'b0) begin errors++; $display("FAIL rrd_oe got %b exp 0", SDA_OE); end
        checks++; if ({BUSY, WR_STB} !== 2'b00) begin errors++; $display("FAIL rrd_busy_stb got %b exp 00", {BUSY, WR_STB}); end
        checks++; if ({WR_ADDR, WR_DATA} !== 16'h0000) begin errors++; $display("FAIL rrd_wr_regs got %h exp 0000", {WR_ADDR, WR_DATA}); end
        wait_q(1);
        sda_m = 1'b1;
        RSTn = 1'b1;
        wait_q(1);
        scl_m = 1'b1;
        wait_q(3);
        read_setup(8'h10, acks);
        get_byte(d, 1'b1);
        bus_stop;
        checks++; if (acks !== 3'b000) begin errors++; $display("FAIL rrd_acks got %b exp 000", acks); end
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rrd_mem_kept got %h exp 5a", d); end
    endtask

`ifdef IIC_EEPROM_WP_EN
    task automatic test_write_protect;
        logic [2:0] acks;
        logic [2:0] wacks;
        logic [7:0] d;
        int         s0;
        s0 = stb_cnt;
        wp = 1'b1;
        bus_start;
        put_byte(8'hA8, wacks[2]);
        put_byte(8'h20, wacks[1]);
        put_byte(8'h77, wacks[0]);
        bus_stop;
        wp = 1'b0;
        checks++; if (wacks !== 3'b000) begin errors++; $display("FAIL wp_acks got %b exp 000", wacks); end
        checks++; if (stb_cnt !== s0) begin errors++; $display("FAIL wp_stb got %0d exp 0", stb_cnt - s0); end
        read_setup(8'h20, acks);
        get_byte(d, 1'b1);
        bus_stop;
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL wp_mem got %h exp ff", d); end
    endtask
`endif

    initial begin
        test_reset;
        test_write_read;
        test_wrap;
        test_wrong_dev;
        test_abort;
        test_reset_read;
`ifdef IIC_EEPROM_WP_EN
        test_write_protect;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
